// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared types and display constants for the seven-segment controller.
package seven_seg_pkg;
    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_0 = 4'b1110;
    localparam logic [3:0] AN_1 = 4'b1101;
    localparam logic [3:0] AN_2 = 4'b1011;
    localparam logic [3:0] AN_3 = 4'b0111;
endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: BCD digit to active-low segment pattern (g..a); non-BCD codes blank.
module bcd_to_7seg
    import seven_seg_pkg::*;
(
    input  bcd_t bcd_i,
    output seg_t seg_o
);
    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/seven_seg_controller.sv
// seven_seg_controller: free-running 4-digit BCD counter on a multiplexed common-anode display.
// Define SSC_LEADING_ZERO_BLANK_EN to blank leading zero digits (ones digit always shown).
module seven_seg_controller
    import seven_seg_pkg::*;
#(
    parameter int COUNT_DIV    = 10_000_000,
    parameter int REFRESH_BITS = 18
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    output logic [3:0] anode,
    output logic [6:0] segment
);
    localparam int PW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;

    logic [PW-1:0]           presc_q, presc_d;
    logic [REFRESH_BITS-1:0] refresh_q;
    logic [15:0]             counter_q, counter_d, counter;
    logic [3:0]              carry, nine;
    logic [1:0]              sel;
    logic                    tick, blank;
    bcd_t                    digit;
    seg_t                    seg_raw;

    assign counter = counter_q;
    assign tick    = presc_q == PW'(COUNT_DIV - 1);
    assign presc_d = tick ? '0 : presc_q + PW'(1);
    assign carry[0] = tick;

    // Ripple the decimal carry through all nibbles within one cycle.
    for (genvar g = 0; g < 4; g++) begin : g_bcd
        assign nine[g] = counter[4*g +: 4] == 4'd9;
        assign counter_d[4*g +: 4] = !carry[g] ? counter[4*g +: 4] :
                                     nine[g]   ? 4'd0 : counter[4*g +: 4] + 4'd1;
        if (g < 3) begin : g_c
            assign carry[g+1] = carry[g] & nine[g];
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            presc_q   <= '0;
            refresh_q <= '0;
            counter_q <= '0;
        end else begin
            presc_q   <= presc_d;
            refresh_q <= refresh_q + REFRESH_BITS'(1);
            counter_q <= counter_d;
        end
    end

    assign sel   = refresh_q[REFRESH_BITS-1 -: 2];
    assign anode = sel == 2'd0 ? AN_0 : sel == 2'd1 ? AN_1 : sel == 2'd2 ? AN_2 : AN_3;
    assign digit = counter[{sel, 2'b00} +: 4];

`ifdef SSC_LEADING_ZERO_BLANK_EN
    assign blank = sel != 2'd0 && (counter >> {sel, 2'b00}) == 16'd0;
`else
    assign blank = 1'b0;
`endif

    bcd_to_7seg u_dec (
        .bcd_i (digit),
        .seg_o (seg_raw)
    );

    assign segment = blank ? SEG_BLANK : seg_raw;
endmodule

// File: tb/tb_seven_seg_controller.sv
// tb_seven_seg_controller: directed checks of count, carry, wrap, scan, async reset and blanking.
module tb_seven_seg_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] anode, anode_b;
    logic [6:0] segment, segment_b;
    int         n = 0;
    int         checks = 0;
    int         fails = 0;
    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    always #5 clk = ~clk;

    seven_seg_controller #(.COUNT_DIV(4), .REFRESH_BITS(4)) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .anode      (anode),
        .segment    (segment)
    );

    // Slower count so a single value is held across a whole scan frame.
    seven_seg_controller #(.COUNT_DIV(64), .REFRESH_BITS(4)) dut_b (
        .clk_100MHz (clk),
        .reset      (reset),
        .anode      (anode_b),
        .segment    (segment_b)
    );

    function automatic logic [6:0] exp_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int pow10(input int s);
        return s == 0 ? 1 : s == 1 ? 10 : s == 2 ? 100 : 1000;
    endfunction

    function automatic logic [6:0] exp_disp(input int val, input int s);
`ifdef SSC_LEADING_ZERO_BLANK_EN
        if (s > 0 && val < pow10(s)) return 7'b1111111;
`endif
        return exp_seg((val / pow10(s)) % 10);
    endfunction

    task automatic step(input int k);
        repeat (k) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (anode !== 4'b1110) begin fails++; $display("FAIL reset_anode: got %b want 1110", anode); end
        checks++; if (segment !== 7'b1000000) begin fails++; $display("FAIL reset_segment: got %b want 1000000", segment); end
        checks++; if (dut.counter !== 16'h0000) begin fails++; $display("FAIL reset_counter: got %h want 0000", dut.counter); end
        checks++; if (dut.digit !== 4'd0) begin fails++; $display("FAIL reset_digit: got %0d want 0", dut.digit); end
        reset = 1'b0;
        n = 0;
        step(3);
        checks++; if (dut.counter !== 16'h0000) begin fails++; $display("FAIL first_tick_early: got %h want 0000", dut.counter); end
        step(1);
        checks++; if (dut.counter !== 16'h0001) begin fails++; $display("FAIL first_tick: got %h want 0001", dut.counter); end
        checks++; if (anode !== 4'b1101) begin fails++; $display("FAIL first_tick_anode: got %b want 1101", anode); end
    endtask

    task automatic test_scan;
        for (int i = 0; i < 16; i++) begin
            int val, s;
            step(1);
            val = n / 4;
            s = (n % 16) / 4;
            checks++; if (anode !== an_tab[s]) begin fails++; $display("FAIL scan_anode n=%0d: got %b want %b", n, anode, an_tab[s]); end
            checks++; if (dut.digit !== 4'((val / pow10(s)) % 10)) begin fails++; $display("FAIL scan_digit n=%0d: got %0d want %0d", n, dut.digit, (val / pow10(s)) % 10); end
            checks++; if (segment !== exp_disp(val, s)) begin fails++; $display("FAIL scan_segment n=%0d: got %b want %b", n, segment, exp_disp(val, s)); end
        end
    endtask

    task automatic test_carry;
        step(39 - n);
        checks++; if (dut.counter !== 16'h0009) begin fails++; $display("FAIL carry_pre: got %h want 0009", dut.counter); end
        step(1);
        checks++; if (dut.counter !== 16'h0010) begin fails++; $display("FAIL carry_post: got %h want 0010", dut.counter); end
        step(12);
        checks++; if (anode !== 4'b1101) begin fails++; $display("FAIL carry_anode: got %b want 1101", anode); end
        checks++; if (segment !== 7'b1111001) begin fails++; $display("FAIL carry_tens_seg: got %b want 1111001", segment); end
    endtask

    task automatic test_wrap;
        step(39999 - n);
        checks++; if (dut.counter !== 16'h9999) begin fails++; $display("FAIL wrap_pre: got %h want 9999", dut.counter); end
        step(1);
        checks++; if (dut.counter !== 16'h0000) begin fails++; $display("FAIL wrap_post: got %h want 0000", dut.counter); end
        checks++; if (anode !== 4'b1110) begin fails++; $display("FAIL wrap_anode: got %b want 1110", anode); end
        checks++; if (segment !== 7'b1000000) begin fails++; $display("FAIL wrap_segment: got %b want 1000000", segment); end
    endtask

    task automatic test_async_reset;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        step(492);
        checks++; if (dut.counter !== 16'h0123) begin fails++; $display("FAIL async_pre: got %h want 0123", dut.counter); end
        #2 reset = 1'b1;
        #1;
        checks++; if (anode !== 4'b1110) begin fails++; $display("FAIL async_anode: got %b want 1110", anode); end
        checks++; if (segment !== 7'b1000000) begin fails++; $display("FAIL async_segment: got %b want 1000000", segment); end
        checks++; if (dut.counter !== 16'h0000) begin fails++; $display("FAIL async_counter: got %h want 0000", dut.counter); end
        @(negedge clk);
        reset = 1'b0;
        n = 0;
    endtask

    task automatic test_blank;
        logic [6:0] lead;
`ifdef SSC_LEADING_ZERO_BLANK_EN
        lead = 7'b1111111;
`else
        lead = 7'b1000000;
`endif
        step(2688);
        checks++; if (dut_b.counter !== 16'h0042) begin fails++; $display("FAIL blank_count: got %h want 0042", dut_b.counter); end
        checks++; if (anode_b !== 4'b1110 || segment_b !== 7'b0100100) begin fails++; $display("FAIL blank_sel0: got %b/%b want 1110/0100100", anode_b, segment_b); end
        step(4);
        checks++; if (anode_b !== 4'b1101 || segment_b !== 7'b0011001) begin fails++; $display("FAIL blank_sel1: got %b/%b want 1101/0011001", anode_b, segment_b); end
        step(4);
        checks++; if (anode_b !== 4'b1011 || segment_b !== lead) begin fails++; $display("FAIL blank_sel2: got %b/%b want 1011/%b", anode_b, segment_b, lead); end
        step(4);
        checks++; if (anode_b !== 4'b0111 || segment_b !== lead) begin fails++; $display("FAIL blank_sel3: got %b/%b want 0111/%b", anode_b, segment_b, lead); end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_carry;
        test_wrap;
        test_async_reset;
        test_blank;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule
